// File: rtl/e_md_ctrl.sv
// E-stage HI/LO controller: owns HI/LO and sequences requests to an external mult/div engine.
// Optional MD_CTRL_FWD_EN forwards engine results to mfhi/mflo on the md_done cycle.
package e_md_ctrl_pkg;
    localparam logic [3:0] HILO_NONE  = 4'd0;
    localparam logic [3:0] HILO_MULT  = 4'd1;
    localparam logic [3:0] HILO_MULTU = 4'd2;
    localparam logic [3:0] HILO_DIV   = 4'd3;
    localparam logic [3:0] HILO_DIVU  = 4'd4;
    localparam logic [3:0] HILO_MFHI  = 4'd5;
    localparam logic [3:0] HILO_MFLO  = 4'd6;
    localparam logic [3:0] HILO_MTHI  = 4'd7;
    localparam logic [3:0] HILO_MTLO  = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} md_state_e;
endpackage

module e_md_ctrl
    import e_md_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [3:0]  HILOOp,
    input  logic        flush,
    input  logic [31:0] RD1,
    input  logic [31:0] RD2,
    output logic        md_start,
    output logic [1:0]  md_op,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    input  logic        md_done,
    input  logic [31:0] md_hi,
    input  logic [31:0] md_lo,
    output logic        stall,
    output logic [31:0] HILOout,
    output logic        err
);
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    md_state_e   state, state_d;
    logic [7:0]  wait_cnt, wait_cnt_d;
    logic [31:0] hi, lo;
    logic        is_md, is_hilo, is_mfhi, is_mflo, fwd_hit, accept;
    logic        issue_go, commit, timeout, mthi_wr, mtlo_wr;
    logic [1:0]  op_code;

    assign is_md   = (HILOOp >= HILO_MULT) && (HILOOp <= HILO_DIVU);
    assign is_hilo = (HILOOp >= HILO_MULT) && (HILOOp <= HILO_MTLO);
    assign is_mfhi = (HILOOp == HILO_MFHI);
    assign is_mflo = (HILOOp == HILO_MFLO);

`ifdef MD_CTRL_FWD_EN
    // Reads may bypass the stall only when the result they need is on md_hi/md_lo right now.
    assign fwd_hit = (state == S_WAIT) && md_done && (is_mfhi || is_mflo);
`else
    assign fwd_hit = 1'b0;
`endif

    assign stall    = op_valid && !flush && is_hilo && (state != S_IDLE) && !fwd_hit;
    assign accept   = op_valid && !flush && !stall;
    assign md_start = (state == S_ISSUE);

    always_comb begin
        case (HILOOp)
            HILO_MULTU: op_code = 2'd1;
            HILO_DIV:   op_code = 2'd2;
            HILO_DIVU:  op_code = 2'd3;
            default:    op_code = 2'd0;
        endcase
    end

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        issue_go   = 1'b0;
        commit     = 1'b0;
        timeout    = 1'b0;
        mthi_wr    = 1'b0;
        mtlo_wr    = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept && is_md) begin
                    issue_go = 1'b1;
                    state_d  = S_ISSUE;
                end
                mthi_wr = accept && (HILOOp == HILO_MTHI);
                mtlo_wr = accept && (HILOOp == HILO_MTLO);
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                // A result on the last allowed cycle still beats the timeout.
                if (md_done) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt + 8'd1;
                    if (wait_cnt == LAST_WAIT) begin
                        timeout = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi    <= '0;
            lo    <= '0;
            md_a  <= '0;
            md_b  <= '0;
            md_op <= '0;
            err   <= 1'b0;
        end else begin
            if (issue_go) begin
                md_a  <= RD1;
                md_b  <= RD2;
                md_op <= op_code;
            end
            if (commit) begin
                hi <= md_hi;
                lo <= md_lo;
            end else begin
                if (mthi_wr) hi <= RD1;
                if (mtlo_wr) lo <= RD1;
            end
            if (timeout) err <= 1'b1;
        end
    end

    always_comb begin
        HILOout = '0;
        if (is_mfhi)      HILOout = fwd_hit ? md_hi : hi;
        else if (is_mflo) HILOout = fwd_hit ? md_lo : lo;
    end
endmodule
